// File: rtl/fa_bist_checker.sv
// On-chip self-test for a full adder: walks all eight {X,Y,Z} vectors past the adder and
// compares its C/S against the expected carry/sum. Reports pass, an error count and the first failing vector.
//
// state | meaning
// IDLE  | waiting for start, operands parked at 0
// APPLY | driving vec, letting the adder settle for SETTLE_CYCLES cycles
// CHECK | comparing C/S against the expected carry/sum for vec
// DONE  | run finished, pass is latched as this cycle ends
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       X,
  output logic       Y,
  output logic       Z,
  input  logic       C,
  input  logic       S,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    err_q, err_d;
  logic [2:0]    ffv_q, ffv_d;
  logic          pass_q, pass_d;
  logic [2:0]    xyz_q, xyz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          exp_s, exp_c, mismatch;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    pass_d   = pass_q;
    exp_s    = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    exp_c    = (vec_q[2] & vec_q[1]) | (vec_q[0] & (vec_q[2] ^ vec_q[1]));
    mismatch = (C != exp_c) || (S != exp_s);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          vec_d   = 3'd0;
          cnt_d   = '0;
          err_d   = 4'd0;
          ffv_d   = 3'd0;
          pass_d  = 1'b0;
        end
      end
      APPLY: begin
        if (cnt_q == CNT_LAST) state_d = CHECK;
        else                   cnt_d = cnt_q + 1'b1;
      end
      CHECK: begin
        // one count per failing vector, regardless of how many bits are wrong
        if (mismatch) begin
          if (err_q != 4'hF) err_d = err_q + 4'd1;
          if (err_q == 4'd0) ffv_d = vec_q;
        end
        if (vec_q == 3'd7) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = '0;
          state_d = APPLY;
        end
      end
      DONE: begin
        pass_d  = (err_q == 4'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    xyz_d  = (state_d == APPLY || state_d == CHECK) ? vec_d : 3'd0;
    busy_d = (state_d != IDLE);
    // done follows the DONE cycle so it coincides with the freshly latched pass
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= '0;
      err_q   <= 4'd0;
      ffv_q   <= 3'd0;
      pass_q  <= 1'b0;
      xyz_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      xyz_q   <= xyz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign X              = xyz_q[2];
  assign Y              = xyz_q[1];
  assign Z              = xyz_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: behavioural full adder with injectable faults, table-driven
// runs plus hand sequences for held start and mid-run reset.
module tb_fa_bist_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic       X1, Y1, Z1, C1, S1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] ffv1;
  logic       X2, Y2, Z2, C2, S2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [2:0] ffv2;
  int         fault;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  // 0 = good adder, 1 = carry stuck-at-0, 2 = sum inverted
  always_comb begin
    C1 = (X1 & Y1) | (Z1 & (X1 ^ Y1));
    S1 = X1 ^ Y1 ^ Z1;
    if (fault == 1) C1 = 1'b0;
    if (fault == 2) S1 = ~S1;
    C2 = (X2 & Y2) | (Z2 & (X2 ^ Y2));
    S2 = X2 ^ Y2 ^ Z2;
  end

  fa_bist_checker #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .X(X1), .Y(Y1), .Z(Z1), .C(C1), .S(S1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail_vec(ffv1));

  fa_bist_checker #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .X(X2), .Y(Y2), .Z(Z2), .C(C2), .S(S2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_fail_vec(ffv2));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    string      name;
    int         sel;
    int         flt;
    int         pulse_at;
    int         lat;
    int         exp_pass;
    int         exp_err;
    int         exp_ffv;
  } vec_t;

  // Starts a run on the selected instance and samples it 1 ns after every edge.
  task automatic run_one(input vec_t v);
    int per, done_c, n_done, seq_bad, sel_pass, sel_err, sel_ffv;
    logic [2:0] xyz, exp_xyz;
    logic b, d;
    per = (v.sel == 1) ? 2 : 3;
    done_c = -1; n_done = 0; seq_bad = 0;
    sel_pass = 0; sel_err = 0; sel_ffv = 0;
    fault = v.flt;
    @(negedge clk);
    if (v.sel == 1) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      xyz = (v.sel == 1) ? {X2, Y2, Z2} : {X1, Y1, Z1};
      b   = (v.sel == 1) ? busy2 : busy1;
      d   = (v.sel == 1) ? done2 : done1;
      exp_xyz = (c < 8 * per) ? 3'(c / per) : 3'd0;
      if (c <= 8 * per + 1 && xyz != exp_xyz) seq_bad++;
      if (c <= 8 * per + 1 && b != (c <= 8 * per)) seq_bad++;
      if (d) begin
        n_done++;
        if (done_c < 0) begin
          done_c   = c;
          sel_pass = (v.sel == 1) ? int'(pass2) : int'(pass1);
          sel_err  = (v.sel == 1) ? int'(err2) : int'(err1);
          sel_ffv  = (v.sel == 1) ? int'(ffv2) : int'(ffv1);
        end
      end
      if (c == v.pulse_at) start1 = 1'b1;
      else start1 = 1'b0;
      if (done_c >= 0 && c >= done_c + 3) break;
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    chk({v.name, " latency"}, done_c, v.lat);
    chk({v.name, " vec_seq_errs"}, seq_bad, 0);
    chk({v.name, " done_pulses"}, n_done, 1);
    chk({v.name, " pass"}, sel_pass, v.exp_pass);
    chk({v.name, " err_count"}, sel_err, v.exp_err);
    chk({v.name, " first_fail_vec"}, sel_ffv, v.exp_ffv);
  endtask

  vec_t tbl[5];

  initial begin
    int n_done, c;
    tbl[0] = '{"good", 0, 0, -1, 25, 1, 0, 0};
    tbl[1] = '{"c_stuck0", 0, 1, -1, 25, 0, 4, 3};
    tbl[2] = '{"s_inv", 0, 2, -1, 25, 0, 8, 0};
    tbl[3] = '{"mid_start", 0, 0, 7, 25, 1, 0, 0};
    tbl[4] = '{"settle1", 1, 0, -1, 17, 1, 0, 0};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; fault = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst xyz", int'({X1, Y1, Z1}), 0);
    chk("rst busy/done/pass", int'({busy1, done1, pass1}), 0);
    chk("rst err_count", int'(err1), 0);
    chk("rst first_fail_vec", int'(ffv1), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 5; i++) run_one(tbl[i]);

    // start held high: back-to-back runs separated by one IDLE cycle
    fault = 2;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    for (c = 0; c < 25; c++) begin
      @(posedge clk); #1;
    end
    chk("held done", int'(done1), 1);
    chk("held idle busy", int'(busy1), 0);
    chk("held err at done", int'(err1), 8);
    @(posedge clk); #1;
    chk("held restart busy", int'(busy1), 1);
    chk("held err reset", int'(err1), 0);
    chk("held pass reset", int'(pass1), 0);
    start1 = 1'b0;
    n_done = 0;
    for (c = 0; c < 40 && n_done == 0; c++) begin
      @(posedge clk); #1;
      if (done1) n_done++;
    end
    chk("held 2nd run done", n_done, 1);
    chk("held 2nd run err", int'(err1), 8);

    // reset during APPLY of vector 4 with carry stuck-at-0
    repeat (2) @(posedge clk);
    fault = 1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (13) begin
      @(posedge clk); #1;
    end
    chk("abort pre xyz", int'({X1, Y1, Z1}), 4);
    chk("abort pre err", int'(err1), 1);
    chk("abort pre ffv", int'(ffv1), 3);
    #2 rst = 1'b1;
    #1;
    chk("abort xyz", int'({X1, Y1, Z1}), 0);
    chk("abort busy/done/pass", int'({busy1, done1, pass1}), 0);
    chk("abort err/ffv", int'({err1, ffv1}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done1 || busy1) n_done++;
    end
    chk("abort no done/busy", n_done, 0);
    run_one('{"after_abort", 0, 0, -1, 25, 1, 0, 0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
